// File: rtl/matrix_keypad_scanner_if.sv
// Keypad pin and key-code handshake bundle for matrix_keypad_scanner.
// master = scanner side, slave = keypad/host side.
interface matrix_keypad_scanner_if #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
);
  localparam int unsigned CODE_W = $clog2(ROWS * COLS);

  logic [ROWS-1:0]   row_in;
  logic [COLS-1:0]   col_out;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;
  logic              key_held;
  logic              overflow;

  modport master (
    input  row_in, key_ready,
    output col_out, key_code, key_valid, key_held, overflow
  );

  modport slave (
    output row_in, key_ready,
    input  col_out, key_code, key_valid, key_held, overflow
  );
endinterface

// File: rtl/matrix_keypad_scanner.sv
// ROWS x COLS keypad scanner: column-strobe scan, row synchroniser, debounce, key-code FIFO.
// Optional auto-repeat of a held key is built only when KEYPAD_SCAN_AUTOREPEAT_EN is defined.
module matrix_keypad_scanner #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SETTLE_CYC   = 2,
  parameter int unsigned DEBOUNCE_CNT = 3,
  parameter int unsigned FIFO_DEPTH   = 4
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_CYC   = 8
`endif
) (
  input logic                     clock,
  input logic                     reset,
  matrix_keypad_scanner_if.master bus
);

  localparam int unsigned CODE_W = $clog2(ROWS * COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 2);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    SCAN     = 4'b0010,
    DEBOUNCE = 4'b0100,
    PRESSED  = 4'b1000
  } state_t;

  state_t            r_state;
  logic [ROWS-1:0]   r_rs_meta;
  logic [ROWS-1:0]   r_rs;
  logic [COLS-1:0]   r_col_out;
  logic [COL_W-1:0]  r_col_idx;
  logic [ROW_W-1:0]  r_row_idx;
  logic [SET_W-1:0]  r_settle;
  logic [DB_W-1:0]   r_cnt;
  logic              r_held;

  logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic              r_overflow;

  logic              w_any_row;
  logic              w_row_hit;
  logic              w_settled;
  logic              w_cnt_last;
  logic              w_new_press;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_push_ok;
  logic [CODE_W-1:0] w_code;
  logic [PTR_W-1:0]  w_rd_next;
  logic [OCC_W-1:0]  w_occ_next;

  function automatic logic [ROW_W-1:0] f_lowest(input logic [ROWS-1:0] v);
    f_lowest = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = ROW_W'(i);
    end
  endfunction

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rs_meta <= '0;
      r_rs      <= '0;
    end else begin
      r_rs_meta <= bus.row_in;
      r_rs      <= r_rs_meta;
    end
  end

  assign w_any_row   = (r_rs != '0);
  assign w_row_hit   = r_rs[r_row_idx];
  assign w_settled   = (r_settle == SET_W'(SETTLE_CYC + 1));
  assign w_cnt_last  = (r_cnt == DB_W'(DEBOUNCE_CNT - 1));
  assign w_code      = CODE_W'(32'(r_row_idx) * COLS + 32'(r_col_idx));
  assign w_new_press = ((r_state == DEBOUNCE) && w_row_hit && w_cnt_last) ||
                       ((r_state == SCAN) && w_settled && w_any_row && (DEBOUNCE_CNT <= 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_col_out <= '1;
      r_col_idx <= '0;
      r_row_idx <= '0;
      r_settle  <= '0;
      r_cnt     <= '0;
      r_held    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_row) begin
            r_state   <= SCAN;
            r_col_idx <= '0;
            r_col_out <= COLS'(1);
            r_settle  <= '0;
          end
        end
        SCAN: begin
          if (!w_settled) begin
            r_settle <= r_settle + SET_W'(1);
          end else if (w_any_row) begin
            r_row_idx <= f_lowest(r_rs);
            r_settle  <= '0;
            if (DEBOUNCE_CNT <= 1) begin
              r_state <= PRESSED;
              r_held  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= DEBOUNCE;
              r_cnt   <= DB_W'(1);
            end
          end else if (r_col_idx == COL_W'(COLS - 1)) begin
            r_state   <= IDLE;
            r_col_out <= '1;
            r_settle  <= '0;
          end else begin
            r_col_idx <= r_col_idx + COL_W'(1);
            r_col_out <= r_col_out << 1;
            r_settle  <= '0;
          end
        end
        DEBOUNCE: begin
          if (!w_row_hit) begin
            r_state   <= IDLE;
            r_col_out <= '1;
            r_cnt     <= '0;
          end else if (w_cnt_last) begin
            r_state <= PRESSED;
            r_held  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        PRESSED: begin
          // r_cnt now counts consecutive released samples
          if (w_row_hit) begin
            r_cnt <= '0;
          end else if (w_cnt_last) begin
            r_state   <= IDLE;
            r_held    <= 1'b0;
            r_col_out <= '1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_col_out <= '1;
          r_held    <= 1'b0;
          r_cnt     <= '0;
          r_settle  <= '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_CYC) ? REPEAT_DELAY : REPEAT_CYC;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic             w_rep_fire;

  assign w_rep_fire = (r_state == PRESSED) &&
                      (r_rep_cnt == (r_rep_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_CYC - 1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (r_state != PRESSED) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt <= r_rep_cnt + RPT_W'(1);
    end
  end

  assign w_push = w_new_press || w_rep_fire;
`else
  assign w_push = w_new_press;
`endif

  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands
  assign w_full     = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_pop      = r_valid && bus.key_ready;
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_rd_next  = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  assign w_occ_next = r_occ + OCC_W'(w_push_ok) - OCC_W'(w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_next;
      r_occ    <= w_occ_next;
      r_valid  <= (w_occ_next != '0);
      if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
        r_code <= w_code;
      end else if (w_occ_next != '0) begin
        r_code <= r_mem[w_rd_next];
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_code;
  end

  assign bus.col_out   = r_col_out;
  assign bus.key_code  = r_code;
  assign bus.key_valid = r_valid;
  assign bus.key_held  = r_held;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Self-checking bench for matrix_keypad_scanner: keypad switch model, queue-based key-code model.
module tb_matrix_keypad_scanner;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned NKEYS   = ROWS * COLS;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LAT_MAX = 2 + (2 + 2) * COLS + 3 + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NKEYS-1:0] keys  = '0;

  int errors   = 0;
  int checks   = 0;
  int pops     = 0;
  int last_pop = -1;
  int p0       = 0;
  int exp_q[$];
  bit model_ovf = 1'b0;
  int t3_codes[5] = '{0, 5, 10, 15, 3};
  int t4_codes[4] = '{1, 2, 4, 8};

  matrix_keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  matrix_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(2), .DEBOUNCE_CNT(3), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Switch matrix: a closed key connects its column strobe to its row
  always_comb begin
    bus.row_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS + c] && bus.col_out[c]) bus.row_in[r] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // First column in scan order wins, then the lowest row within it
  function automatic int exp_code(input logic [NKEYS-1:0] k);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (k[r*COLS + c]) return r*COLS + c;
    return -1;
  endfunction

  task automatic model_press(input int code);
    if (exp_q.size() >= int'(DEPTH)) model_ovf = 1'b1;
    else exp_q.push_back(code);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys = '0;
    bus.key_ready = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic press(input int code, input int hold, input int gap);
    keys = '0;
    keys[code] = 1'b1;
    model_press(exp_code(keys));
    tick(hold);
    keys = '0;
    tick(gap);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (bus.key_valid) seen = 1'b1;
    end
    check(name, 32'(seen), 1);
  endtask

  // Per-cycle comparison of the output side against the model queue
  always @(negedge clock) begin
    if (!reset) begin
      check("col_out_shape", 32'($onehot(bus.col_out) || (bus.col_out == '1)), 1);
      if (bus.key_valid && bus.key_ready) begin
        pops++;
        last_pop = int'(bus.key_code);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got code %0d, expected no entry at t=%0t", bus.key_code, $time);
        end else begin
          check("pop_code", 32'(bus.key_code), exp_q.pop_front());
        end
      end else if (bus.key_valid && exp_q.size() != 0) begin
        check("head_code", 32'(bus.key_code), exp_q[0]);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish before t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.key_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_col_out", 32'(bus.col_out), 4'b1111);
    check("rst_valid", 32'(bus.key_valid), 0);
    check("rst_code", 32'(bus.key_code), 0);
    check("rst_held", 32'(bus.key_held), 0);
    check("rst_overflow", 32'(bus.overflow), 0);

    // Key row 2 / col 1 held about 50 cycles
    do_reset();
    p0 = pops;
    keys = '0;
    keys[2*COLS + 1] = 1'b1;
    model_press(exp_code(keys));
    wait_valid("t1_latency", LAT_MAX);
    tick(40);
    check("t1_held", 32'(bus.key_held), 1);
    check("t1_col_hold", 32'(bus.col_out), 4'b0010);
    keys = '0;
    tick(12);
    check("t1_col_idle", 32'(bus.col_out), 4'b1111);
    check("t1_held_rel", 32'(bus.key_held), 0);
    check("t1_pops", 32'(pops - p0), 1);
    check("t1_code", 32'(last_pop), 9);

    // Several keys at once: column 1 found first, row 1 lowest in it
    p0 = pops;
    keys = '0;
    keys[5] = 1'b1; keys[6] = 1'b1; keys[13] = 1'b1;
    model_press(exp_code(keys));
    tick(40);
    keys = '0;
    tick(15);
    check("mk_pops", 32'(pops - p0), 1);
    check("mk_code", 32'(last_pop), 5);

    // Bounces: a 5-cycle contact dies in debounce, a 1-cycle one is never found
    do_reset();
    p0 = pops;
    keys[0] = 1'b1;
    tick(5);
    keys = '0;
    tick(30);
    keys[0] = 1'b1;
    tick(1);
    keys = '0;
    tick(30);
    check("t2_valid", 32'(bus.key_valid), 0);
    check("t2_col_idle", 32'(bus.col_out), 4'b1111);
    check("t2_held", 32'(bus.key_held), 0);
    check("t2_pops", 32'(pops - p0), 0);

    // Consumer stalled: fifth press is dropped
    do_reset();
    bus.key_ready = 1'b0;
    p0 = pops;
    foreach (t3_codes[i]) press(t3_codes[i], 30, 15);
    check("t3_overflow", 32'(bus.overflow), 1);
    check("t3_overflow_model", 32'(bus.overflow), 32'(model_ovf));
    check("t3_valid", 32'(bus.key_valid), 1);
    check("t3_head", 32'(bus.key_code), 0);
    bus.key_ready = 1'b1;
    tick(10);
    check("t3_pops", 32'(pops - p0), 4);
    check("t3_last", 32'(last_pop), 15);
    check("t3_empty", 32'(bus.key_valid), 0);
    check("t3_overflow_sticky", 32'(bus.overflow), 1);

    // Full FIFO, pop on the very cycle the new code is pushed (key 0 pushes 9 edges after contact)
    do_reset();
    bus.key_ready = 1'b0;
    p0 = pops;
    foreach (t4_codes[i]) press(t4_codes[i], 30, 15);
    keys = '0;
    keys[0] = 1'b1;
    tick(8);
    bus.key_ready = 1'b1;
    tick(1);
    bus.key_ready = 1'b0;
    model_press(0);
    tick(10);
    check("t4_overflow", 32'(bus.overflow), 0);
    check("t4_held", 32'(bus.key_held), 1);
    check("t4_head", 32'(bus.key_code), 2);
    keys = '0;
    tick(15);
    bus.key_ready = 1'b1;
    tick(10);
    check("t4_pops", 32'(pops - p0), 5);
    check("t4_last", 32'(last_pop), 0);
    check("t4_drained", 32'(exp_q.size()), 0);

    // Reset while a key is held with two codes queued
    do_reset();
    bus.key_ready = 1'b0;
    press(1, 30, 15);
    keys = '0;
    keys[2] = 1'b1;
    model_press(exp_code(keys));
    tick(30);
    check("t5_held_before", 32'(bus.key_held), 1);
    check("t5_valid_before", 32'(bus.key_valid), 1);
    reset = 1'b1;
    keys = '0;
    exp_q.delete();
    model_ovf = 1'b0;
    @(negedge clock);
    check("t5_valid", 32'(bus.key_valid), 0);
    check("t5_col_out", 32'(bus.col_out), 4'b1111);
    check("t5_overflow", 32'(bus.overflow), 0);
    check("t5_held", 32'(bus.key_held), 0);
    check("t5_code", 32'(bus.key_code), 0);
    tick(2);
    reset = 1'b0;
    bus.key_ready = 1'b1;
    tick(5);

    // Key 7 held 40 cycles past its push
    do_reset();
    p0 = pops;
    keys = '0;
    keys[7] = 1'b1;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    repeat (5) exp_q.push_back(7);
`else
    exp_q.push_back(7);
`endif
    tick(62);
    check("t6_held", 32'(bus.key_held), 1);
    keys = '0;
    tick(15);
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    check("t6_pops", 32'(pops - p0), 5);
`else
    check("t6_pops", 32'(pops - p0), 1);
`endif
    check("t6_code", 32'(last_pop), 7);
    check("t6_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
